// File: rtl/clock_divider_monitor_pkg.sv
// clock_divider_monitor_pkg: shared state encoding and default widths
package clock_divider_monitor_pkg;
  localparam int DEF_CNT_W = 8;
  localparam int DEF_ERR_W = 8;
  typedef enum logic [1:0] {IDLE, ACQUIRE, TRACK, LOCKED} state_t;
endpackage

// File: rtl/edge_pulse_gen.sv
// edge_pulse_gen: registers din once and emits registered rise/fall pulses plus a comb edge flag
module edge_pulse_gen (
  input  logic clk,
  input  logic rst,
  input  logic din,
  input  logic en,
  output logic rise_pulse,
  output logic fall_pulse,
  output logic e
);
  logic s1;
  assign e = din ^ s1;
  always_ff @(posedge clk) begin
    if (rst) begin
      s1 <= 1'b0;
      rise_pulse <= 1'b0;
      fall_pulse <= 1'b0;
    end else begin
      s1 <= din;
      rise_pulse <= en & din & ~s1;
      fall_pulse <= en & ~din & s1;
    end
  end
endmodule

// File: rtl/clock_divider_monitor.sv
// clock_divider_monitor: edge pulses, half-period measurement, lock tracking and error counting for a divided clock
module clock_divider_monitor
  import clock_divider_monitor_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W,
  parameter int LOCK_CYCLES = 4,
  parameter int ERR_W = DEF_ERR_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             din,
  input  logic             en,
  input  logic [CNT_W-1:0] exp_half,
  output logic             rise_pulse,
  output logic             fall_pulse,
  output logic             locked,
  output logic             err_pulse,
  output logic [ERR_W-1:0] err_count,
  output logic [CNT_W-1:0] meas_half
);
  localparam int GW = $clog2(LOCK_CYCLES + 1);
  state_t state;
  logic e, valid, stuck, good, bad;
  logic [CNT_W-1:0] run;
  logic [GW-1:0] good_cnt;
  edge_pulse_gen u_edge (
    .clk(clk),
    .rst(rst),
    .din(din),
    .en(en),
    .rise_pulse(rise_pulse),
    .fall_pulse(fall_pulse),
    .e(e)
  );
  assign valid = e && run != '0;
  assign stuck = !e && run >= exp_half;
  assign good = valid && run == exp_half;
  assign bad = (valid && run != exp_half) || stuck;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      run <= '0;
      good_cnt <= '0;
      locked <= 1'b0;
      err_pulse <= 1'b0;
      err_count <= '0;
      meas_half <= '0;
    end else begin
      run <= !en ? '0 : e ? CNT_W'(1) : (run == '0 || &run) ? run : run + CNT_W'(1);
      meas_half <= valid ? run : meas_half;
      err_pulse <= 1'b0;
      if (!en) begin
        state <= IDLE;
        good_cnt <= '0;
        locked <= 1'b0;
      end else begin
        case (state)
          IDLE: state <= ACQUIRE;
          ACQUIRE: if (e && exp_half != '0) begin
            state <= TRACK;
            good_cnt <= '0;
          end
          TRACK: if (good) begin
            good_cnt <= good_cnt + GW'(1);
            if (good_cnt == GW'(LOCK_CYCLES - 1)) begin
              state <= LOCKED;
              locked <= 1'b1;
            end
          end else if (bad) good_cnt <= '0;
          LOCKED: if (bad) begin
            err_pulse <= 1'b1;
            err_count <= &err_count ? err_count : err_count + ERR_W'(1);
            state <= TRACK;
            good_cnt <= '0;
            locked <= 1'b0;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: doc/clock_divider_monitor.md
Name: clock_divider_monitor

Overview:
- Downstream consumer of the divide-by-2 / divide-by-N divider output; samples the divided signal in the source clk domain.
- Generates single-cycle rise/fall enable pulses for logic that must not use the divided signal as a clock.
- Measures every half-period against a programmed expectation, declares lock after N consecutive good halves, and flags/counts period errors (wrong ratio, stuck output).

Parameters:
- CNT_W, 8, width of half-period counter, exp_half and meas_half.
- LOCK_CYCLES, 4, consecutive matching half-periods required to assert locked (≥1).
- ERR_W, 8, width of saturating error counter.

Ports:
- clk  in  1  system clock; same clock that drives the divider.
- rst  in  1  synchronous, active-high reset.
- din  in  1  divided signal (divider dout), synchronous to clk.
- en  in  1  monitor enable; 0 holds FSM in IDLE.
- exp_half  in  CNT_W  expected half-period in clk cycles (1 for divide-by-2).
- rise_pulse  out  1  one-cycle pulse per din 0→1.
- fall_pulse  out  1  one-cycle pulse per din 1→0.
- locked  out  1  high while in LOCKED.
- err_pulse  out  1  one-cycle pulse per error detected in LOCKED.
- err_count  out  ERR_W  saturating error count.
- meas_half  out  CNT_W  last measured half-period.

Behaviour:
- Reset: all outputs 0; s1=0, run=0, good_cnt=0, state=IDLE. Reset mid-operation aborts everything next edge; err_count cleared only by rst.
- s1 <= din each cycle; edge e = din ^ s1 (comb). rise_pulse <= en & din & ~s1; fall_pulse <= en & ~din & s1. Latency: pulse high the cycle after din changes, exactly one cycle.
- run counter: en=0 → run<=0; e → run<=1; else run<=run+1 saturating at all-ones, except run==0 stays 0 (no reference edge yet).
- Measurement valid at an edge cycle when run≠0: measured half = run; meas_half <= run.
- FSM states IDLE, ACQUIRE, TRACK, LOCKED. en=0 from any state → IDLE next cycle; good_cnt, locked cleared; meas_half held.
- IDLE → ACQUIRE when en=1.
- ACQUIRE: wait for first e (run==0, no measurement) → TRACK, good_cnt=0. exp_half==0: FSM stays in ACQUIRE indefinitely (invalid config); pulses still generated.
- TRACK: valid measurement == exp_half → good_cnt+1; when incremented value reaches LOCK_CYCLES → LOCKED (locked=1 next cycle). Mismatch, or stuck (no e and run ≥ exp_half) → good_cnt=0, stay TRACK, no err_pulse.
- LOCKED: mismatch at edge, or stuck condition (no e and run ≥ exp_half) → err_pulse=1 for one cycle, err_count+1 (saturate at all-ones), → TRACK with good_cnt=0, locked drops next cycle. Stuck error fires once; re-arms only after relock.
- exp_half changed while locked: next measurement compared against new value; mismatch is an error.
- run saturation: all-ones with no edge in LOCKED is already a stuck error; no wrap-around.

Decomposition:
- Package clock_divider_monitor_pkg: state enum (IDLE, ACQUIRE, TRACK, LOCKED), default CNT_W/ERR_W constants.
- One sub-module: edge_pulse_gen (s1 register, rise/fall pulse generation, e output).

Test Plan:
- Divide-by-2 din (toggles every clk), exp_half=1, en=1 → rise/fall pulses alternate every cycle; locked=1 after first edge + 4 good halves; meas_half=1; err_count=0.
- Divide-by-4 din, exp_half=2 → lock; then force din constant → err_pulse once 2 cycles after last edge, err_count=1, locked=0; restore toggling → relock after 4 halves.
- Locked on exp_half=1, switch exp_half to 2 → err_pulse on next edge, err_count=1, never relocks while din stays divide-by-2.
- exp_half=0, divide-by-2 din → pulses present, locked stays 0, err_count stays 0.
- Force 300 errors with ERR_W=8 → err_count saturates at 255.
- Assert rst while locked (err_count=3) → next cycle all outputs 0; deassert en mid-TRACK → IDLE, locked=0, err_count retained.
